alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Issue/sequencing controller for the ALU datapath: ALU, shifter, HI/LO register pair and the result mux.
- Accepts one decoded R-type op at a time and produces the 6-bit mux select code.
- Runs the multi-cycle MULTU multiplier through a fixed step count, then commits HI/LO.
- Stalls new ops while the multiplier is busy, so MFHI/MFLO never read stale HI/LO.

Parameters:
- MUL_CYCLES, 32: number of multiplier step cycles per MULTU (must be >= 2).
- FUNCT_W, 6: width of the function code and mux select.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  upstream presents an op.
- funct  input  FUNCT_W  function code of the presented op.
- op_ready  output  1  controller can accept an op this cycle.
- mux_sel  output  FUNCT_W  select code driven to the result mux (registered).
- res_valid  output  1  mux output is a completed result this cycle.
- rf_we  output  1  write result to register file.
- op_err  output  1  completed op had an illegal funct.
- mul_start  output  1  one-cycle pulse: multiplier loads its operands.
- mul_step  output  1  multiplier performs one iteration.
- hilo_we  output  1  HI/LO registers capture the multiplier product.
- busy  output  1  multiply in progress (MUL_RUN or MUL_WB).

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Legal codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001, MFHI 010000, MFLO 010010. Any other code is illegal.
- Reset (while reset=1 and the following cycle state=IDLE):
  - state=IDLE, counter=0, mux_sel=0.
  - res_valid, rf_we, op_err, mul_start, mul_step, hilo_we, busy all 0.
  - op_ready=0 while reset is high.
- Accept occurs on a rising edge where op_valid&&op_ready; funct is latched into mux_sel on that edge.
- States:
  - IDLE: op_ready=1, no result.
    - Accept non-MULTU legal op -> EXEC.
    - Accept MULTU -> MUL_RUN, counter=0.
    - Accept illegal op -> EXEC with error latched.
  - EXEC (1 cycle):
    - res_valid=1; rf_we=1 unless error; op_err=error.
    - op_ready=1, so back-to-back issue is allowed.
    - Accept -> same transitions as IDLE; else -> IDLE.
    - Single-cycle latency: issue edge N, result cycle N+1.
  - MUL_RUN:
    - mul_step=1 every cycle; mul_start=1 only in the first cycle (counter==0).
    - Counter increments each cycle; at counter==MUL_CYCLES-1 -> MUL_WB.
    - op_ready=0, busy=1.
  - MUL_WB (1 cycle):
    - hilo_we=1, res_valid=1, rf_we=0, mux_sel=011001, busy=1, op_ready=0.
    - -> IDLE.
- MULTU total: MUL_CYCLES step cycles + 1 writeback cycle; next accept is possible in cycle N+MUL_CYCLES+2.
- op_valid held while op_ready=0 is not consumed; upstream keeps funct stable until accepted.
- mux_sel holds its last value when no result is valid.
- Reset mid-multiply: aborts the op immediately. No hilo_we or res_valid is issued, and HI/LO keep their old contents.
- Counter width is clog2(MUL_CYCLES); it never wraps because exit happens at MUL_CYCLES-1.
- Outputs are decoded from registered state/latched funct only; no combinational path from funct to any output.

Decomposition:
- Shared package alu_pkg holds:
  - the funct localparams (AND, OR, ADD, SUB, SLT, SRL, MULTU, MFHI, MFLO);
  - state encoding IDLE/EXEC/MUL_RUN/MUL_WB;
  - function is_legal_funct.
- One sub-module, mul_step_counter: loadable up-counter with terminal-count flag, parameterised by MUL_CYCLES.

Test Plan:
- Reset with op_valid=1, funct=100000 held -> op_ready=0 during reset; all outputs 0; first accept on the first edge after reset deasserts.
- ADD (100000) issued at edge 0 -> cycle 1: res_valid=1, rf_we=1, mux_sel=100000, op_err=0. Then SUB (100010) back-to-back at edge 1 -> cycle 2 result, mux_sel=100010.
- MULTU issued at edge 0 (MUL_CYCLES=32):
  - mul_start=1 in cycle 1 only; mul_step=1 in cycles 1..32.
  - hilo_we=1 and res_valid=1 in cycle 33, with rf_we=0.
  - op_ready=0 in cycles 1..33; busy=1 in cycles 1..33.
- MFHI (010000) held valid from cycle 1 during MULTU -> not accepted until edge 34; result in cycle 35 with mux_sel=010000, rf_we=1.
- Illegal funct 111111 -> next cycle: res_valid=1, op_err=1, rf_we=0.
- reset pulsed in cycle 10 of a MULTU -> hilo_we never asserts; IDLE and op_ready=1 in the cycle after reset drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/sequencing controller: function codes,
// controller state encoding and the legal-code check.
package alu_pkg;

   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SRL   = 6'b000010;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StMulRun,
      StMulWb
   } state_e;

   // True for every function code the datapath implements.
   function automatic logic is_legal_funct(input logic [5:0] f);
      logic legal;
      case (f)
         FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT,
         FUNCT_SRL, FUNCT_MULTU, FUNCT_MFHI, FUNCT_MFLO: legal = 1'b1;
         default:                                        legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Loadable up-counter for multiplier steps; flags the last step so the
// controller can move to writeback. Holds at the terminal count.
module mul_step_counter #(
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: load to zero, otherwise step while enabled and not terminal.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (en_i && !tc_o) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal count marks the final step cycle.
   always_comb begin
      tc_o = (count_q == CNT_W'(MUL_CYCLES - 1));
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue/sequencing controller for the ALU datapath. Accepts one decoded op at a
// time, drives the result mux select, and sequences MULTU through its step
// cycles and HI/LO writeback while stalling further issue.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 32,
   parameter int unsigned FUNCT_W    = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_valid,
   input  logic [FUNCT_W-1:0] funct,
   output logic               op_ready,
   output logic [FUNCT_W-1:0] mux_sel,
   output logic               res_valid,
   output logic               rf_we,
   output logic               op_err,
   output logic               mul_start,
   output logic               mul_step,
   output logic               hilo_we,
   output logic               busy
);

   state_e             state_q, state_d;
   logic               err_q, err_d;
   logic [FUNCT_W-1:0] mux_sel_q, mux_sel_d;
   logic               res_valid_q, res_valid_d;
   logic               rf_we_q, rf_we_d;
   logic               op_err_q, op_err_d;
   logic               mul_start_q, mul_start_d;
   logic               mul_step_q, mul_step_d;
   logic               hilo_we_q, hilo_we_d;
   logic               busy_q, busy_d;

   logic accept;
   logic legal;
   logic is_multu;
   logic cnt_load;
   logic cnt_en;
   logic cnt_tc;

   mul_step_counter #(
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul_step_counter (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (cnt_load),
      .en_i    (cnt_en),
      .tc_o    (cnt_tc)
   );

   // Ready only from registered state; held low while reset is asserted.
   always_comb begin
      op_ready = !reset && ((state_q == StIdle) || (state_q == StExec));
      accept   = op_valid && op_ready;
      legal    = is_legal_funct(6'(funct));
      is_multu = (funct == FUNCT_W'(FUNCT_MULTU));
   end

   // Next-state and next-output decode; outputs are registered from state_d.
   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      mux_sel_d = mux_sel_q;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;

      unique case (state_q)
         StIdle, StExec: begin
            if (accept) begin
               mux_sel_d = funct;
               err_d     = !legal;
               if (legal && is_multu) begin
                  state_d  = StMulRun;
                  cnt_load = 1'b1;
               end else begin
                  state_d = StExec;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StMulRun: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               state_d   = StMulWb;
               mux_sel_d = FUNCT_W'(FUNCT_MULTU);
            end
         end
         StMulWb: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      res_valid_d = (state_d == StExec) || (state_d == StMulWb);
      rf_we_d     = (state_d == StExec) && !err_d;
      op_err_d    = (state_d == StExec) && err_d;
      mul_start_d = cnt_load;
      mul_step_d  = (state_d == StMulRun);
      hilo_we_d   = (state_d == StMulWb);
      busy_d      = (state_d == StMulRun) || (state_d == StMulWb);
   end

   // Controller state and registered outputs; reset aborts any multiply.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         err_q       <= 1'b0;
         mux_sel_q   <= '0;
         res_valid_q <= 1'b0;
         rf_we_q     <= 1'b0;
         op_err_q    <= 1'b0;
         mul_start_q <= 1'b0;
         mul_step_q  <= 1'b0;
         hilo_we_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         mux_sel_q   <= mux_sel_d;
         res_valid_q <= res_valid_d;
         rf_we_q     <= rf_we_d;
         op_err_q    <= op_err_d;
         mul_start_q <= mul_start_d;
         mul_step_q  <= mul_step_d;
         hilo_we_q   <= hilo_we_d;
         busy_q      <= busy_d;
      end
   end

   assign mux_sel   = mux_sel_q;
   assign res_valid = res_valid_q;
   assign rf_we     = rf_we_q;
   assign op_err    = op_err_q;
   assign mul_start = mul_start_q;
   assign mul_step  = mul_step_q;
   assign hilo_we   = hilo_we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table-driven single-cycle ops with a
// result scoreboard, plus directed MULTU, stall and reset-abort sequences.
module tb_alu_seq_ctrl;

   localparam int MUL_CYCLES = 32;

   typedef struct packed {
      logic [5:0] mux;
      logic       rf_we;
      logic       err;
      logic       hilo;
   } exp_t;

   typedef struct {
      logic [5:0] funct;
      logic       legal;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic [5:0] funct = 6'b0;
   logic       op_ready;
   logic [5:0] mux_sel;
   logic       res_valid;
   logic       rf_we;
   logic       op_err;
   logic       mul_start;
   logic       mul_step;
   logic       hilo_we;
   logic       busy;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   vec_t vecs[12];

   alu_seq_ctrl #(
      .MUL_CYCLES (MUL_CYCLES),
      .FUNCT_W    (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .funct     (funct),
      .op_ready  (op_ready),
      .mux_sel   (mux_sel),
      .res_valid (res_valid),
      .rf_we     (rf_we),
      .op_err    (op_err),
      .mul_start (mul_start),
      .mul_step  (mul_step),
      .hilo_we   (hilo_we),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [5:0] m, input logic w, input logic e, input logic h);
      exp_t r;
      r.mux   = m;
      r.rf_we = w;
      r.err   = e;
      r.hilo  = h;
      return r;
   endfunction

   // Scoreboard: every completed result must match the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (res_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got result mux_sel=%0h expected no result", mux_sel);
         end else begin
            e = sb_q.pop_front();
            chk("sb_mux_sel", mux_sel, e.mux);
            chk("sb_rf_we", rf_we, e.rf_we);
            chk("sb_op_err", op_err, e.err);
            chk("sb_hilo_we", hilo_we, e.hilo);
         end
      end else begin
         chk("idle_strobes", {rf_we, op_err, hilo_we}, 3'b000);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic hilo_seen;

      vecs[0]  = '{6'b100100, 1'b1};  // AND
      vecs[1]  = '{6'b100101, 1'b1};  // OR
      vecs[2]  = '{6'b100000, 1'b1};  // ADD
      vecs[3]  = '{6'b100010, 1'b1};  // SUB
      vecs[4]  = '{6'b101010, 1'b1};  // SLT
      vecs[5]  = '{6'b000010, 1'b1};  // SRL
      vecs[6]  = '{6'b010000, 1'b1};  // MFHI
      vecs[7]  = '{6'b111111, 1'b0};
      vecs[8]  = '{6'b000000, 1'b0};
      vecs[9]  = '{6'b100001, 1'b0};
      vecs[10] = '{6'b011000, 1'b0};
      vecs[11] = '{6'b010010, 1'b1};  // MFLO

      // Reset held with a valid ADD presented: nothing may be accepted.
      reset    = 1'b1;
      op_valid = 1'b1;
      funct    = 6'b100000;
      #1;
      chk("rst_ready_pre", op_ready, 1'b0);
      repeat (3) begin
         tick();
         chk("rst_op_ready", op_ready, 1'b0);
         chk("rst_outs", {res_valid, rf_we, op_err, mul_start, mul_step, hilo_we, busy}, 7'b0);
         chk("rst_mux_sel", mux_sel, 6'b0);
      end
      reset = 1'b0;
      #1;
      chk("post_rst_ready", op_ready, 1'b1);
      sb_q.push_back(mk(6'b100000, 1'b1, 1'b0, 1'b0));
      tick();
      op_valid = 1'b0;
      chk("first_add_valid", res_valid, 1'b1);
      chk("first_add_sel", mux_sel, 6'b100000);
      tick();

      // Back-to-back single-cycle ops, legal and illegal.
      for (int i = 0; i < 12; i++) begin
         chk("b2b_ready", op_ready, 1'b1);
         op_valid = 1'b1;
         funct    = vecs[i].funct;
         sb_q.push_back(mk(vecs[i].funct, vecs[i].legal, !vecs[i].legal, 1'b0));
         tick();
         chk("b2b_res_valid", res_valid, 1'b1);
      end
      op_valid = 1'b0;
      funct    = 6'b000000;
      tick();
      chk("hold_no_result", res_valid, 1'b0);
      chk("hold_mux_sel", mux_sel, 6'b010010);
      tick();
      chk("hold_mux_sel2", mux_sel, 6'b010010);

      // MULTU with MFHI held valid throughout the multiply.
      chk("mul_ready", op_ready, 1'b1);
      op_valid = 1'b1;
      funct    = 6'b011001;
      sb_q.push_back(mk(6'b011001, 1'b0, 1'b0, 1'b1));
      tick();
      funct = 6'b010000;
      for (int c = 1; c <= MUL_CYCLES + 1; c++) begin
         chk("mul_op_ready", op_ready, 1'b0);
         chk("mul_busy", busy, 1'b1);
         chk("mul_start", mul_start, (c == 1));
         chk("mul_step", mul_step, (c <= MUL_CYCLES));
         chk("mul_hilo_we", hilo_we, (c == MUL_CYCLES + 1));
         tick();
      end
      chk("mul_done_ready", op_ready, 1'b1);
      chk("mul_done_busy", busy, 1'b0);
      sb_q.push_back(mk(6'b010000, 1'b1, 1'b0, 1'b0));
      tick();
      op_valid = 1'b0;
      chk("mfhi_valid", res_valid, 1'b1);
      chk("mfhi_sel", mux_sel, 6'b010000);
      chk("mfhi_rf_we", rf_we, 1'b1);
      tick();

      // Reset in cycle 10 of a MULTU aborts it with no writeback.
      hilo_seen = 1'b0;
      op_valid  = 1'b1;
      funct     = 6'b011001;
      tick();
      op_valid = 1'b0;
      repeat (9) begin
         hilo_seen |= hilo_we;
         tick();
      end
      chk("abort_running", mul_step, 1'b1);
      reset = 1'b1;
      #1;
      chk("abort_rst_ready", op_ready, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("abort_ready", op_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_step", mul_step, 1'b0);
      repeat (MUL_CYCLES + 8) begin
         hilo_seen |= hilo_we;
         tick();
      end
      chk("abort_no_hilo", hilo_seen, 1'b0);

      // Controller still issues normally after the abort.
      op_valid = 1'b1;
      funct    = 6'b100010;
      sb_q.push_back(mk(6'b100010, 1'b1, 1'b0, 1'b0));
      tick();
      op_valid = 1'b0;
      chk("after_abort_sel", mux_sel, 6'b100010);
      tick();
      tick();

      chk("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
